// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the iterative RV64M multiply/divide sequencer.
// Contents: funct3 op codes, sequencer state enum, datapath ALU control encodings.
// Used by muldiv_seq and by anything that drives or observes it.
package muldiv_pkg;

  // RV64M funct3 codes handled by the sequencer (001/010/011 are not supported)
  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  // Shared datapath ALU aluControl encodings
  localparam logic [2:0] ALU_ADDSUB = 3'b000;
  localparam logic [2:0] ALU_SLL    = 3'b001;
  localparam logic [2:0] ALU_SLTU   = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEGA,
    S_NEGB,
    S_MUL_IT,
    S_DIV_IT,
    S_FIX,
    S_SPEC,
    S_DONE
  } state_t;

  // funct3[2] marks the whole DIV/DIVU/REM/REMU family
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M MUL/DIV/DIVU/REM/REMU borrowing the datapath ALU while busy.
// Latency start->done: 65 (MUL/DIVU/REMU), 68 (DIV/REM), 2 (div-by-zero/overflow/unsupported).
// No backpressure: start is accepted only in IDLE/DONE, ignored while busy; kill aborts.
// Ports: clk/rst_n; start/kill/opSel/srcA/srcB request; busy/done/result status;
//        aluA/aluB/aluCtl/aluM drive the shared ALU, aluOut is its combinational result.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      opSel,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] aluA,
  output logic [XLEN-1:0] aluB,
  output logic [2:0]      aluCtl,
  output logic            aluM,
  input  logic [XLEN-1:0] aluOut
);

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN-1);

  state_t          r_state, w_state_nxt, w_start_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_x;      // multiplicand, then dividend magnitude / quotient
  logic [XLEN-1:0] r_y;      // multiplier, then divisor magnitude
  logic [XLEN-1:0] r_acc;    // product accumulator / partial remainder
  logic [XLEN-1:0] r_result;
  logic [CNTW-1:0] r_cnt;
  logic            r_negq, r_negr;

  logic            w_busy, w_last, w_op_signed, w_start_spec, w_ge, w_fix_neg;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_q_nxt, w_r_nxt, w_mul_nxt, w_spec_res, w_fix_x;

  assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign w_last      = (r_cnt == '0);
  assign w_op_signed = (r_op == OP_DIV) || (r_op == OP_REM);

  // Restoring-division step: the 65-bit compare is local, only R - D uses the ALU.
  // When the shifted remainder carries out, R - D still fits in XLEN bits.
  assign w_rem_sh  = {r_acc, r_x[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_y});
  assign w_r_nxt   = w_ge ? aluOut : w_rem_sh[XLEN-1:0];
  assign w_q_nxt   = {r_x[XLEN-2:0], w_ge};
  assign w_mul_nxt = r_y[0] ? aluOut : r_acc;

  assign w_fix_x   = (r_op == OP_DIV) ? r_x : r_acc;
  assign w_fix_neg = (r_op == OP_DIV) ? r_negq : r_negr;

  // Path chosen from the raw request, before it is captured
  always_comb begin
    w_start_spec = 1'b0;
    if ((opSel != OP_MUL) && !is_div_op(opSel))
      w_start_spec = 1'b1;
    else if (is_div_op(opSel) && (srcB == '0))
      w_start_spec = 1'b1;
    else if (((opSel == OP_DIV) || (opSel == OP_REM)) && (srcA == MIN_NEG) && (srcB == '1))
      w_start_spec = 1'b1;

    w_start_state = S_NEGA;
    if (w_start_spec)                                  w_start_state = S_SPEC;
    else if (opSel == OP_MUL)                          w_start_state = S_MUL_IT;
    else if ((opSel == OP_DIVU) || (opSel == OP_REMU)) w_start_state = S_DIV_IT;
  end

  // Only div-by-zero and signed overflow of a div op reach here besides unsupported ops
  always_comb begin
    w_spec_res = '0;
    if (is_div_op(r_op)) begin
      if (r_y == '0)
        w_spec_res = r_op[1] ? r_x : '1;   // funct3[1] set = REM/REMU
      else if (r_op == OP_DIV)
        w_spec_res = MIN_NEG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    aluA        = '0;
    aluB        = '0;
    aluCtl      = '0;
    aluM        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_start_state;
      S_DONE: w_state_nxt = start ? w_start_state : S_IDLE;
      S_NEGA: begin
        aluCtl      = ALU_ADDSUB;
        aluB        = r_x;
        aluM        = r_x[XLEN-1];
        w_state_nxt = S_NEGB;
      end
      S_NEGB: begin
        aluCtl      = ALU_ADDSUB;
        aluB        = r_y;
        aluM        = r_y[XLEN-1];
        w_state_nxt = S_DIV_IT;
      end
      S_MUL_IT: begin
        aluCtl = ALU_ADDSUB;
        aluA   = r_acc;
        aluB   = r_x;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DIV_IT: begin
        aluCtl = ALU_ADDSUB;
        aluA   = w_rem_sh[XLEN-1:0];
        aluB   = r_y;
        aluM   = 1'b1;
        if (w_last) w_state_nxt = w_op_signed ? S_FIX : S_DONE;
      end
      S_FIX: begin
        aluCtl      = ALU_ADDSUB;
        aluB        = w_fix_x;
        aluM        = w_fix_neg;
        w_state_nxt = S_DONE;
      end
      S_SPEC:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (kill && w_busy) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
    end else if (kill && w_busy) begin
      // abandoned: operand state is reloaded by the next start, result is kept
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_op   <= opSel;
          r_x    <= srcA;
          r_y    <= srcB;
          r_acc  <= '0;
          r_cnt  <= CNT_LAST;
          r_negq <= srcA[XLEN-1] ^ srcB[XLEN-1];
          r_negr <= srcA[XLEN-1];
        end
        S_NEGA: r_x <= aluOut;
        S_NEGB: r_y <= aluOut;
        S_MUL_IT: begin
          r_acc <= w_mul_nxt;
          r_x   <= r_x << 1;
          r_y   <= r_y >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) r_result <= w_mul_nxt;
        end
        S_DIV_IT: begin
          r_acc <= w_r_nxt;
          r_x   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (w_last && !w_op_signed)
            r_result <= (r_op == OP_DIVU) ? w_q_nxt : w_r_nxt;
        end
        S_FIX:   r_result <= aluOut;
        S_SPEC:  r_result <= w_spec_res;
        default: ;
      endcase
    end
  end

endmodule
